cg_iteration_controller: RTL and testbench

Parametrised conjugate-gradient iteration sequencer that drives the existing dot-product, matrix-by-vector, divider and vector-update units through one full solve. It replaces the hard-wired flag-chaining inside the solver ALU with an explicit state machine. It also adds a run-time tolerance, an iteration limit, an initial-residual convergence check, ceil-rounded beat counts and read back-pressure. It sits between the top-level solver control and the arithmetic datapath.

---
 rtl/cg_pkg.sv | 46 ++++
 rtl/cg_iteration_controller_if.sv | 39 +++
 rtl/cg_beat_counter.sv | 43 ++++
 rtl/cg_iteration_controller.sv | 171 +++++++++++++++++
 tb/tb_cg_iteration_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cg_pkg.sv
// ---------------------------------------------------------------------------
// cg_pkg
// Shared definitions for the conjugate-gradient iteration controller:
//   - cg_state_e  : sequencer state encoding (also exported as a debug output)
//   - OP_*        : op_sel codes selecting the arithmetic unit to launch
//   - ELEM_W_DEF  : default scalar width (IEEE-754 single)
//   - op_for_state: maps a sequencer state to the unit it drives
// ---------------------------------------------------------------------------
package cg_pkg;

    localparam int ELEM_W_DEF = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RR0   = 4'd1,
        ST_AP    = 4'd2,
        ST_DIVA  = 4'd3,
        ST_XRUPD = 4'd4,
        ST_RRNEW = 4'd5,
        ST_DIVB  = 4'd6,
        ST_PUPD  = 4'd7,
        ST_FIN   = 4'd8
    } cg_state_e;

    localparam logic [2:0] OP_RR        = 3'd0;
    localparam logic [2:0] OP_AP        = 3'd1;
    localparam logic [2:0] OP_DIV_ALPHA = 3'd2;
    localparam logic [2:0] OP_XR_UPD    = 3'd3;
    localparam logic [2:0] OP_DIV_BETA  = 3'd4;
    localparam logic [2:0] OP_P_UPD     = 3'd5;

    function automatic logic [2:0] op_for_state(input cg_state_e s);
        logic [2:0] op;
        op = OP_RR;
        case (s)
            ST_AP:    op = OP_AP;
            ST_DIVA:  op = OP_DIV_ALPHA;
            ST_XRUPD: op = OP_XR_UPD;
            ST_DIVB:  op = OP_DIV_BETA;
            ST_PUPD:  op = OP_P_UPD;
            default:  op = OP_RR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cg_iteration_controller_if.sv
// ---------------------------------------------------------------------------
// cg_iteration_controller_if
// Bus between the iteration controller (master) and the arithmetic units
// (slave).
//   op_start  : one-cycle launch of the unit chosen by op_sel
//   op_sel    : unit select (OP_* codes in cg_pkg)
//   op_done   : completion from the selected unit, op_result valid with it
//   rd_strobe : residual-vector read beat during RR phases
//   rd_ready  : read port can accept a beat
//   div_num/den : divider operands, stable for the whole DIV state
//
// Handshake: a read beat transfers in exactly the cycles where rd_strobe is
// high; rd_strobe is never raised unless rd_ready is high in that same
// cycle, so the read port never has to hold off a strobe it already saw.
// op_start/op_done is a launch/complete pair: op_done is honoured from the
// op_start cycle onward, and only while the launching state is current.
// ---------------------------------------------------------------------------
interface cg_iteration_controller_if #(
    parameter int ELEM_W = 32
);
    logic              op_start;
    logic [2:0]        op_sel;
    logic              op_done;
    logic [ELEM_W-1:0] op_result;
    logic              rd_strobe;
    logic              rd_ready;
    logic [ELEM_W-1:0] div_num;
    logic [ELEM_W-1:0] div_den;

    modport master (
        output op_start, op_sel, rd_strobe, div_num, div_den,
        input  op_done, op_result, rd_ready
    );

    modport slave (
        input  op_start, op_sel, rd_strobe, div_num, div_den,
        output op_done, op_result, rd_ready
    );
endinterface

// File: rtl/cg_beat_counter.sv
// ---------------------------------------------------------------------------
// cg_beat_counter
// Issues ceil(total/NUM_LANES) residual read beats per RR phase, gated by
// rd_ready. One instance serves both RR phases since they never overlap.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the beat count (pulsed the cycle before RR entry)
//   active     : controller is in an RR phase
//   total      : vector length for the current solve
//   rd_ready   : read port can accept a beat
//   rd_strobe  : beat issued this cycle
// ---------------------------------------------------------------------------
module cg_beat_counter #(
    parameter int NUM_LANES = 8,
    parameter int LEN_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             active,
    input  logic [LEN_W-1:0] total,
    input  logic             rd_ready,
    output logic             rd_strobe
);
    localparam int               SH   = $clog2(NUM_LANES);
    localparam logic [LEN_W-1:0] MASK = LEN_W'(NUM_LANES - 1);

    logic [LEN_W-1:0] beats;
    logic [LEN_W-1:0] issued_q;

    // Shift-and-round-up form cannot overflow near the top of the length range.
    assign beats     = (total >> SH) + LEN_W'(|(total & MASK));
    assign rd_strobe = active && (issued_q < beats) && rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
        end else if (clear) begin
            issued_q <= '0;
        end else if (rd_strobe) begin
            issued_q <= issued_q + LEN_W'(1);
        end
    end
endmodule

// File: rtl/cg_iteration_controller.sv
// ---------------------------------------------------------------------------
// cg_iteration_controller
// Sequences one conjugate-gradient solve across the dot-product, mat-vec,
// divider and vector-update units.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a solve (ignored while busy)
//   total/tolerance/max_iter : solve parameters, sampled on accepted start
//   unit                : unit launch/complete bus, residual reads, divider operands
//   alpha, beta         : latest step scalars
//   busy, done, converged : status; done pulses for one cycle in FIN
//   iter_count          : completed iterations
//   dbg_state           : current sequencer state
// ---------------------------------------------------------------------------
module cg_iteration_controller
    import cg_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int ELEM_W    = ELEM_W_DEF,
    parameter int LEN_W     = 32,
    parameter int ITER_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     total,
    input  logic [ELEM_W-1:0]    tolerance,
    input  logic [ITER_W-1:0]    max_iter,
    cg_iteration_controller_if.master unit,
    output logic [ELEM_W-1:0]    alpha,
    output logic [ELEM_W-1:0]    beta,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [ITER_W-1:0]    iter_count,
    output cg_state_e            dbg_state
);
    cg_state_e         state_q, state_d;
    logic              launch_q, launch_d;
    logic              rr_entry;
    logic              rs_le_tol;
    logic [ITER_W-1:0] iter_inc;
    logic [LEN_W-1:0]  total_q;
    logic [ELEM_W-1:0] tol_q, rs_old_q, rs_new_q, pap_q, alpha_q, beta_q;
    logic [ITER_W-1:0] max_iter_q, iter_q;
    logic              conv_q;

    // Raw-bit unsigned compare is sound: dot products are non-negative floats.
    assign rs_le_tol = (unit.op_result <= tol_q);
    assign iter_inc  = iter_q + ITER_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (total == '0) ? ST_FIN : ST_RR0;
            ST_RR0:   if (unit.op_done) state_d = rs_le_tol ? ST_FIN : ST_AP;
            ST_AP:    if (unit.op_done) state_d = ST_DIVA;
            ST_DIVA:  if (unit.op_done) state_d = ST_XRUPD;
            ST_XRUPD: if (unit.op_done) state_d = ST_RRNEW;
            ST_RRNEW: begin
                if (unit.op_done) begin
                    if (rs_le_tol)
                        state_d = ST_FIN;
                    else if ((max_iter_q != '0) && (iter_inc == max_iter_q))
                        state_d = ST_FIN;
                    else
                        state_d = ST_DIVB;
                end
            end
            ST_DIVB:  if (unit.op_done) state_d = ST_PUPD;
            ST_PUPD:  if (unit.op_done) state_d = ST_AP;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Every state change enters a new state, so a change into a unit
        // state is exactly its first cycle and deserves an op_start.
        launch_d = (state_d != state_q) && (state_d != ST_IDLE) && (state_d != ST_FIN);
        rr_entry = (state_d != state_q) && ((state_d == ST_RR0) || (state_d == ST_RRNEW));

        unit.op_start = launch_q;
        unit.op_sel   = op_for_state(state_q);
        unit.div_num  = '0;
        unit.div_den  = '0;
        if (state_q == ST_DIVA) begin
            unit.div_num = rs_old_q;
            unit.div_den = pap_q;
        end else if (state_q == ST_DIVB) begin
            unit.div_num = rs_new_q;
            unit.div_den = rs_old_q;
        end
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FIN);
        alpha      = alpha_q;
        beta       = beta_q;
        converged  = conv_q;
        iter_count = iter_q;
        dbg_state  = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            launch_q   <= 1'b0;
            total_q    <= '0;
            tol_q      <= '0;
            max_iter_q <= '0;
            rs_old_q   <= '0;
            rs_new_q   <= '0;
            pap_q      <= '0;
            alpha_q    <= '0;
            beta_q     <= '0;
            iter_q     <= '0;
            conv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        total_q    <= total;
                        tol_q      <= tolerance;
                        max_iter_q <= max_iter;
                        rs_old_q   <= '0;
                        rs_new_q   <= '0;
                        pap_q      <= '0;
                        alpha_q    <= '0;
                        beta_q     <= '0;
                        iter_q     <= '0;
                        // An empty vector is trivially solved.
                        conv_q     <= (total == '0);
                    end
                end
                ST_RR0: begin
                    if (unit.op_done) begin
                        rs_old_q <= unit.op_result;
                        conv_q   <= rs_le_tol;
                    end
                end
                ST_AP:   if (unit.op_done) pap_q   <= unit.op_result;
                ST_DIVA: if (unit.op_done) alpha_q <= unit.op_result;
                ST_RRNEW: begin
                    if (unit.op_done) begin
                        rs_new_q <= unit.op_result;
                        iter_q   <= iter_inc;
                        conv_q   <= rs_le_tol;
                    end
                end
                ST_DIVB: begin
                    if (unit.op_done) begin
                        beta_q   <= unit.op_result;
                        rs_old_q <= rs_new_q;
                    end
                end
                default: ;
            endcase
        end
    end

    cg_beat_counter #(
        .NUM_LANES (NUM_LANES),
        .LEN_W     (LEN_W)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (rr_entry),
        .active    ((state_q == ST_RR0) || (state_q == ST_RRNEW)),
        .total     (total_q),
        .rd_ready  (unit.rd_ready),
        .rd_strobe (unit.rd_strobe)
    );
endmodule

// File: tb/tb_cg_iteration_controller.sv
// ---------------------------------------------------------------------------
// tb_cg_iteration_controller
// Directed bench: scripted unit responses, hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cg_iteration_controller;
    import cg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] total = '0;
    logic [31:0] tolerance = '0;
    logic [15:0] max_iter = '0;
    logic [31:0] alpha, beta;
    logic        busy, done, converged;
    logic [15:0] iter_count;
    cg_state_e   dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;
    int base;
    int ops;

    cg_iteration_controller_if #(.ELEM_W(32)) unit_bus ();

    cg_iteration_controller #(
        .NUM_LANES (8),
        .ELEM_W    (32),
        .LEN_W     (32),
        .ITER_W    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .total      (total),
        .tolerance  (tolerance),
        .max_iter   (max_iter),
        .unit       (unit_bus),
        .alpha      (alpha),
        .beta       (beta),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (unit_bus.rd_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] t, input logic [31:0] tol, input logic [15:0] mi);
        total = t;
        tolerance = tol;
        max_iter = mi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [2:0] sel);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (unit_bus.op_start === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_sel"}, 32'(unit_bus.op_sel), 32'(sel));
    endtask

    task automatic respond(input logic [31:0] res, input int lat);
        repeat (lat) @(negedge clk);
        unit_bus.op_done = 1'b1;
        unit_bus.op_result = res;
        @(negedge clk);
        unit_bus.op_done = 1'b0;
        unit_bus.op_result = '0;
    endtask

    task automatic wait_done(input string tag, output int op_starts);
        logic seen;
        seen = 1'b0;
        op_starts = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (unit_bus.op_start === 1'b1) op_starts++;
                @(negedge clk);
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    logic [31:0] pap_v [3] = '{32'h3F800000, 32'h3F000000, 32'h3E800000};
    logic [31:0] alp_v [3] = '{32'h40000000, 32'h40800000, 32'h41000000};
    logic [31:0] rsn_v [3] = '{32'h3F000000, 32'h3E000000, 32'h39000000};
    logic [31:0] bet_v [3] = '{32'h3E800000, 32'h3E000000, 32'h0};
    logic [31:0] rso_v [3] = '{32'h40000000, 32'h3F000000, 32'h3E000000};

    initial begin
        unit_bus.op_done = 1'b0;
        unit_bus.op_result = '0;
        unit_bus.rd_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_conv", 32'(converged), 0);
        check("rst_alpha", alpha, 0);
        check("rst_beta", beta, 0);
        check("rst_iter", 32'(iter_count), 0);
        check("rst_opstart", 32'(unit_bus.op_start), 0);
        check("rst_strobe", 32'(unit_bus.rd_strobe), 0);
        check("rst_divnum", unit_bus.div_num, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // total=16 -> 2 beats, converges on first residual
        base = strobe_cnt;
        do_start(32'd16, 32'hFFFFFFFF, 16'd0);
        check("t16_busy", 32'(busy), 1);
        wait_start("t16_rr0", OP_RR);
        respond(32'h3F800000, 5);
        wait_done("t16", ops);
        check("t16_strobes", 32'(strobe_cnt - base), 2);
        check("t16_conv", 32'(converged), 1);
        @(negedge clk);
        check("t16_idle_busy", 32'(busy), 0);
        check("t16_conv_hold", 32'(converged), 1);

        // total=17 -> 3 beats with a 4-cycle rd_ready stall
        base = strobe_cnt;
        do_start(32'd17, 32'hFFFFFFFF, 16'd0);
        wait_start("t17_rr0", OP_RR);
        @(negedge clk);
        unit_bus.rd_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("t17_paused", 32'(strobe_cnt - base), 1);
        unit_bus.rd_ready = 1'b1;
        respond(32'h3F800000, 6);
        wait_done("t17", ops);
        check("t17_strobes", 32'(strobe_cnt - base), 3);

        // Initial residual already below tolerance
        @(negedge clk);
        do_start(32'd8, 32'h283424DC, 16'd0);
        wait_start("init_rr0", OP_RR);
        respond(32'h28000000, 2);
        wait_done("init", ops);
        check("init_no_ap", 32'(ops), 0);
        check("init_conv", 32'(converged), 1);
        check("init_iter", 32'(iter_count), 0);

        // Three full iterations, converging on the third
        @(negedge clk);
        do_start(32'd64, 32'h3A000000, 16'd0);
        wait_start("full_rr0", OP_RR);
        respond(32'h40000000, 3);
        for (int k = 0; k < 3; k++) begin
            wait_start("full_ap", OP_AP);
            respond(pap_v[k], 2);
            wait_start("full_diva", OP_DIV_ALPHA);
            check("full_diva_num", unit_bus.div_num, rso_v[k]);
            check("full_diva_den", unit_bus.div_den, pap_v[k]);
            respond(alp_v[k], 1);
            wait_start("full_xr", OP_XR_UPD);
            check("full_alpha", alpha, alp_v[k]);
            respond(32'h0, 3);
            wait_start("full_rrnew", OP_RR);
            respond(rsn_v[k], 2);
            if (k < 2) begin
                wait_start("full_divb", OP_DIV_BETA);
                check("full_iter", 32'(iter_count), 32'(k + 1));
                check("full_divb_num", unit_bus.div_num, rsn_v[k]);
                check("full_divb_den", unit_bus.div_den, rso_v[k]);
                respond(bet_v[k], 1);
                wait_start("full_pupd", OP_P_UPD);
                check("full_beta", beta, bet_v[k]);
                respond(32'h0, 2);
            end
        end
        wait_done("full", ops);
        check("full_conv", 32'(converged), 1);
        check("full_iter_final", 32'(iter_count), 3);
        check("full_alpha_final", alpha, 32'h41000000);
        check("full_beta_final", beta, 32'h3E000000);

        // Iteration limit reached without convergence
        @(negedge clk);
        do_start(32'd8, 32'h3A000000, 16'd2);
        check("lim_cleared_iter", 32'(iter_count), 0);
        wait_start("lim_rr0", OP_RR);
        respond(32'h40000000, 1);
        for (int k = 0; k < 2; k++) begin
            wait_start("lim_ap", OP_AP);
            respond(32'h3F800000, 1);
            wait_start("lim_diva", OP_DIV_ALPHA);
            respond(32'h40000000, 1);
            wait_start("lim_xr", OP_XR_UPD);
            respond(32'h0, 1);
            wait_start("lim_rrnew", OP_RR);
            respond(32'h3F800000, 1);
            if (k == 0) begin
                wait_start("lim_divb", OP_DIV_BETA);
                respond(32'h3F000000, 1);
                wait_start("lim_pupd", OP_P_UPD);
                respond(32'h0, 0);
            end
        end
        wait_done("lim", ops);
        check("lim_no_more_ops", 32'(ops), 0);
        check("lim_conv", 32'(converged), 0);
        check("lim_iter", 32'(iter_count), 2);

        // Reset in XRUPD, then a clean solve
        @(negedge clk);
        do_start(32'd8, 32'h3A000000, 16'd0);
        wait_start("rst_rr0", OP_RR);
        respond(32'h40000000, 1);
        wait_start("rst_ap", OP_AP);
        respond(32'h3F800000, 1);
        wait_start("rst_diva", OP_DIV_ALPHA);
        respond(32'h40000000, 1);
        wait_start("rst_xr", OP_XR_UPD);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_opstart", 32'(unit_bus.op_start), 0);
        check("mid_rst_strobe", 32'(unit_bus.rd_strobe), 0);
        check("mid_rst_alpha", alpha, 0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        do_start(32'd8, 32'h3A000000, 16'd0);
        wait_start("clean_rr0", OP_RR);
        respond(32'h39000000, 2);
        wait_done("clean", ops);
        check("clean_conv", 32'(converged), 1);
        check("clean_iter", 32'(iter_count), 0);

        // Stray op_done in IDLE, start while busy
        @(negedge clk);
        unit_bus.op_done = 1'b1;
        unit_bus.op_result = 32'h12345678;
        @(negedge clk);
        unit_bus.op_done = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(busy), 0);
        check("stray_state", 32'(dbg_state), 32'(ST_IDLE));
        check("stray_opstart", 32'(unit_bus.op_start), 0);
        base = strobe_cnt;
        do_start(32'd8, 32'h3A000000, 16'd0);
        wait_start("busy_rr0", OP_RR);
        @(negedge clk);
        do_start(32'd64, 32'hFFFFFFFF, 16'd0);
        check("busy_state", 32'(dbg_state), 32'(ST_RR0));
        check("busy_opstart", 32'(unit_bus.op_start), 0);
        respond(32'h39000000, 6);
        wait_done("busy", ops);
        check("busy_strobes", 32'(strobe_cnt - base), 1);
        check("busy_conv", 32'(converged), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
